hizasiz_bellek_islem_birimi: RTL and testbench
==============================================

# hizasiz_bellek_islem_birimi

Parametrised load/store unit for the execute stage, successor to the single-cycle word-bus unit. It accepts one load/store per request, drives a `VERI_GENISLIGI`-wide data bus, and registers the result. When enabled, it transparently splits lane-crossing (misaligned) accesses into two bus transactions. It sits between `yurut` and the data-bus arbiter and reports completion with a pulse instead of a combinational done.

## Interface
- `VERI_GENISLIGI`, 32: bus data width; 32 or 64. `NB = VERI_GENISLIGI/8` byte lanes.
- `ADRES_GENISLIGI`, 32: address width.
- `HIZASIZ_DESTEK`, 1: 1 = split lane-crossing accesses; 0 = reject them with `hata_o`.

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `basla_i`  in  1  request strobe; accepted only when `mesgul_o=0`.
- `kontrol_i`  in  3  `BIB_LB/LH/LW/LBU/LHU/SB/SH/SW`.
- `adr_i`  in  `ADRES_GENISLIGI`  byte address.
- `deger_i`  in  32  store data, LSB-aligned.
- `ddb_durdur_i`  in  1  pipeline hold; suppresses bus select and freezes state.
- `mesgul_o`  out  1  request in progress.
- `bitti_o`  out  1  one-cycle completion pulse.
- `hata_o`  out  1  one-cycle pulse with `bitti_o` on a rejected misaligned access.
- `sonuc_o`  out  32  registered load result; held until the next load completes.
- `bib_veri_i`  in  `VERI_GENISLIGI`  read data; valid in the completing cycle.
- `bib_durdur_i`  in  1  bus not ready.
- `bib_veri_o`  out  `VERI_GENISLIGI`  lane-shifted store data.
- `bib_adr_o`  out  `ADRES_GENISLIGI`  lane-aligned address; low `log2(NB)` bits are 0.
- `bib_veri_maske_o`  out  `NB`  byte write enables; all 0 for loads.
- `bib_sec_o`  out  1  bus select.

## Operation
- **Request decode:**
  - Size is 1, 2 or 4 bytes, taken from `kontrol_i`.
  - `off = adr_i mod NB`.
  - The access crosses lanes when `off + size > NB`.
- **Accept:**
  - On `basla_i & ~mesgul_o`, register `kontrol_i`, `adr_i` and `deger_i`.
  - `basla_i` while busy is ignored.
- **State machine:** `BOSTA`, `ILK`, `IKINCI`, `BITTI`.
  - `BOSTA` → `ILK` on accept. If `HIZASIZ_DESTEK=0` and the access is crossing, go `BOSTA` → `BITTI` with the error flag set and issue no bus access.
  - `ILK`: `bib_adr_o = aligned(adr)`, `bib_sec_o = ~ddb_durdur_i`. The transaction completes when `bib_sec_o & ~bib_durdur_i`. On completion go to `IKINCI` if crossing, else `BITTI`.
  - `IKINCI`: `bib_adr_o = aligned(adr) + NB`, wrapping modulo 2^`ADRES_GENISLIGI`. On completion go to `BITTI`.
  - `BITTI`: `bitti_o=1`, `hata_o` = error flag; next state is `BOSTA`.
- **Store data path:**
  - Form a `2*VERI_GENISLIGI` vector: `deger_i << 8*off`, with the byte mask `((1<<size)-1) << off`.
  - The low half drives the `ILK` transaction; the high half drives the `IKINCI` transaction.
- **Load data path:**
  - `ILK` data goes into the low half of a `2*VERI_GENISLIGI` buffer; `IKINCI` data goes into the high half.
  - Shift the buffer right by `8*off`, take `size` bytes, then sign- or zero-extend per `kontrol_i`.
  - Register the result into `sonuc_o` at entry to `BITTI`.
- **Stores:** `sonuc_o` is unchanged.

## Timing
- **Reset:** `rst_i=0` forces `BOSTA` immediately. Reset values:
  - `mesgul_o=0`, `bitti_o=0`, `hata_o=0`, `bib_sec_o=0`.
  - `bib_veri_maske_o=0`, `bib_adr_o=0`, `bib_veri_o=0`, `sonuc_o=0`.
  - A mid-transaction reset abandons the access; no completion pulse follows.
- **Aligned, no stall:** accept at cycle 0; bus cycle 1; `bitti_o` at cycle 2.
- **Crossing:** bus cycles 1 and 2; `bitti_o` at cycle 3.
- **Rejected access:** `bitti_o` and `hata_o` at cycle 1.
- **Stalls:** each `bib_durdur_i` or `ddb_durdur_i` cycle during `ILK`/`IKINCI` adds one cycle. Address, data and mask stay stable across stalls.
- **`mesgul_o`:** 1 in `ILK`, `IKINCI` and `BITTI`. A new request is accepted in the cycle after `bitti_o`.
- **`bib_sec_o`:** never asserted in `BOSTA` or `BITTI`.

## Structure
- `tanimlamalar.vh` holds:
  - the existing `BIB_*` operation codes;
  - new state encodings `BIB_BOSTA`, `BIB_ILK`, `BIB_IKINCI`, `BIB_BITTI`;
  - a size-from-`kontrol` macro.
- One combinational sub-module, `bib_hizalayici`, parametrised by `VERI_GENISLIGI`. It produces:
  - the store shift and mask for both halves;
  - load extraction and extension from the 2W buffer.
- The top module holds the FSM, the request registers, the read buffer and `sonuc_o`.

## Test plan
- **LW aligned, `adr=0x100`, W=32, bus returns `0xDEADBEEF` with no stall:**
  - one bus cycle at `bib_adr_o=0x100`;
  - `bitti_o` at cycle 2;
  - `sonuc_o=0xDEADBEEF`.
- **LH at `adr=0x103`, W=32, reads `0x80000000` then `0x000000FF`:**
  - bus cycles at `0x100`, then `0x104`;
  - `sonuc_o=0xFFFFFF80`;
  - `bitti_o` at cycle 3.
- **SW of `0x11223344` at `adr=0x106`, W=32:**
  - first transaction: `bib_veri_o=0x33440000`, mask `1100`;
  - second at `0x108`: `bib_veri_o=0x00001122`, mask `0011`.
- **`HIZASIZ_DESTEK=0`, LW at `0x101`:**
  - no `bib_sec_o`;
  - `bitti_o` and `hata_o` at cycle 1;
  - `sonuc_o` unchanged.
- **SB of `0xAB` at `0x10D`, W=64, `bib_durdur_i` high for 3 cycles:**
  - `bib_adr_o=0x108`, mask `0x20`, `bib_veri_o[47:40]=0xAB`, all stable during the stall;
  - `bitti_o` at cycle 5.
- **`rst_i` low during `IKINCI`:**
  - all outputs at reset values immediately;
  - no `bitti_o` afterwards;
  - the next request completes normally.

Source files
------------

// File: rtl/hizasiz_bellek_islem_birimi_pkg.sv
// Shared operation codes, FSM states and decode helpers for the misaligned load/store unit.
package hizasiz_bellek_islem_birimi_pkg;

    localparam logic [2:0] BIB_LB  = 3'd0;
    localparam logic [2:0] BIB_LH  = 3'd1;
    localparam logic [2:0] BIB_LW  = 3'd2;
    localparam logic [2:0] BIB_LBU = 3'd3;
    localparam logic [2:0] BIB_LHU = 3'd4;
    localparam logic [2:0] BIB_SB  = 3'd5;
    localparam logic [2:0] BIB_SH  = 3'd6;
    localparam logic [2:0] BIB_SW  = 3'd7;

    typedef enum logic [1:0] {
        BIB_BOSTA,
        BIB_ILK,
        BIB_IKINCI,
        BIB_BITTI
    } bib_durum_e;

    // Access size in bytes.
    function automatic logic [2:0] bib_boyut(input logic [2:0] kontrol);
        logic [2:0] boyut;
        case (kontrol)
            BIB_LW, BIB_SW:          boyut = 3'd4;
            BIB_LH, BIB_LHU, BIB_SH: boyut = 3'd2;
            default:                 boyut = 3'd1;
        endcase
        return boyut;
    endfunction

    function automatic logic bib_yazma(input logic [2:0] kontrol);
        return (kontrol == BIB_SB) || (kontrol == BIB_SH) || (kontrol == BIB_SW);
    endfunction

endpackage

// File: rtl/hizasiz_bellek_islem_birimi_hizalayici.sv
// Lane aligner: store shift/mask over a double-width window and load extraction/extension.
module hizasiz_bellek_islem_birimi_hizalayici
    import hizasiz_bellek_islem_birimi_pkg::*;
#(
    parameter int unsigned VERI_GENISLIGI = 32,
    localparam int unsigned NB = VERI_GENISLIGI / 8,
    localparam int unsigned OW = $clog2(NB)
) (
    input  logic [2:0]                  kontrol_i,
    input  logic [OW-1:0]               ofset_i,
    input  logic [31:0]                 deger_i,
    input  logic [2*VERI_GENISLIGI-1:0] tampon_i,
    output logic [2*VERI_GENISLIGI-1:0] yaz_veri_o,
    output logic [2*NB-1:0]             yaz_maske_o,
    output logic [31:0]                 yuk_sonuc_o
);

    logic [31:0]     deger_kirp;
    logic [2*NB-1:0] maske_temel;
    logic [7:0]      bayt [4];

    // Clip store data to the access size so unused upper bytes never reach the bus.
    always_comb begin
        deger_kirp       = deger_i;
        maske_temel      = '0;
        maske_temel[3:0] = 4'b1111;
        case (bib_boyut(kontrol_i))
            3'd1: begin
                deger_kirp       = {24'd0, deger_i[7:0]};
                maske_temel[3:0] = 4'b0001;
            end
            3'd2: begin
                deger_kirp       = {16'd0, deger_i[15:0]};
                maske_temel[3:0] = 4'b0011;
            end
            default: ;
        endcase
    end

    assign yaz_veri_o  = {{(2*VERI_GENISLIGI-32){1'b0}}, deger_kirp} << {ofset_i, 3'b000};
    assign yaz_maske_o = maske_temel << ofset_i;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bayt[k] = tampon_i[8*(int'(ofset_i) + k) +: 8];
        end
    end

    always_comb begin
        case (kontrol_i)
            BIB_LB:  yuk_sonuc_o = {{24{bayt[0][7]}}, bayt[0]};
            BIB_LH:  yuk_sonuc_o = {{16{bayt[1][7]}}, bayt[1], bayt[0]};
            BIB_LW:  yuk_sonuc_o = {bayt[3], bayt[2], bayt[1], bayt[0]};
            BIB_LBU: yuk_sonuc_o = {24'd0, bayt[0]};
            BIB_LHU: yuk_sonuc_o = {16'd0, bayt[1], bayt[0]};
            default: yuk_sonuc_o = '0;
        endcase
    end

endmodule

// File: rtl/hizasiz_bellek_islem_birimi.sv
// Execute-stage load/store unit; splits lane-crossing accesses into two bus transactions.
module hizasiz_bellek_islem_birimi
    import hizasiz_bellek_islem_birimi_pkg::*;
#(
    parameter int unsigned VERI_GENISLIGI  = 32,
    parameter int unsigned ADRES_GENISLIGI = 32,
    parameter int unsigned HIZASIZ_DESTEK  = 1,
    localparam int unsigned NB = VERI_GENISLIGI / 8,
    localparam int unsigned OW = $clog2(NB)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       basla_i,
    input  logic [2:0]                 kontrol_i,
    input  logic [ADRES_GENISLIGI-1:0] adr_i,
    input  logic [31:0]                deger_i,
    input  logic                       ddb_durdur_i,
    output logic                       mesgul_o,
    output logic                       bitti_o,
    output logic                       hata_o,
    output logic [31:0]                sonuc_o,
    input  logic [VERI_GENISLIGI-1:0]  bib_veri_i,
    input  logic                       bib_durdur_i,
    output logic [VERI_GENISLIGI-1:0]  bib_veri_o,
    output logic [ADRES_GENISLIGI-1:0] bib_adr_o,
    output logic [NB-1:0]              bib_veri_maske_o,
    output logic                       bib_sec_o
);

    bib_durum_e                 durum_q, durum_d;
    logic [2:0]                 kontrol_q;
    logic [ADRES_GENISLIGI-1:0] adr_q;
    logic [31:0]                deger_q;
    logic                       hata_q, hata_d;
    logic [2*VERI_GENISLIGI-1:0] tampon_q, tampon_d;
    logic [31:0]                sonuc_q, sonuc_d;

    logic                       kabul, giris_capraz, capraz, yazma, aktif, tamam;
    logic [ADRES_GENISLIGI-1:0] hizali_adr;
    logic [2*VERI_GENISLIGI-1:0] yaz_veri;
    logic [2*NB-1:0]            yaz_maske;
    logic [31:0]                yuk_sonuc;

    assign kabul        = basla_i && (durum_q == BIB_BOSTA);
    assign giris_capraz = (32'(adr_i[OW-1:0]) + 32'(bib_boyut(kontrol_i))) > NB;
    assign capraz       = (32'(adr_q[OW-1:0]) + 32'(bib_boyut(kontrol_q))) > NB;
    assign yazma        = bib_yazma(kontrol_q);
    assign aktif        = (durum_q == BIB_ILK) || (durum_q == BIB_IKINCI);
    assign tamam        = bib_sec_o && !bib_durdur_i;
    assign hizali_adr   = {adr_q[ADRES_GENISLIGI-1:OW], {OW{1'b0}}};

    hizasiz_bellek_islem_birimi_hizalayici #(
        .VERI_GENISLIGI(VERI_GENISLIGI)
    ) u_hizalayici (
        .kontrol_i  (kontrol_q),
        .ofset_i    (adr_q[OW-1:0]),
        .deger_i    (deger_q),
        .tampon_i   (tampon_d),
        .yaz_veri_o (yaz_veri),
        .yaz_maske_o(yaz_maske),
        .yuk_sonuc_o(yuk_sonuc)
    );

    // Read buffer kept separate so load extraction sees the completing beat without a loop.
    always_comb begin
        tampon_d = tampon_q;
        if (tamam) begin
            if (durum_q == BIB_ILK) begin
                tampon_d[VERI_GENISLIGI-1:0] = bib_veri_i;
            end else begin
                tampon_d[2*VERI_GENISLIGI-1:VERI_GENISLIGI] = bib_veri_i;
            end
        end
    end

    always_comb begin
        durum_d = durum_q;
        hata_d  = hata_q;
        sonuc_d = sonuc_q;
        case (durum_q)
            BIB_BOSTA: begin
                if (kabul) begin
                    if ((HIZASIZ_DESTEK == 0) && giris_capraz) begin
                        durum_d = BIB_BITTI;
                        hata_d  = 1'b1;
                    end else begin
                        durum_d = BIB_ILK;
                        hata_d  = 1'b0;
                    end
                end
            end
            BIB_ILK: begin
                if (tamam) begin
                    if (capraz) begin
                        durum_d = BIB_IKINCI;
                    end else begin
                        durum_d = BIB_BITTI;
                        if (!yazma) sonuc_d = yuk_sonuc;
                    end
                end
            end
            BIB_IKINCI: begin
                if (tamam) begin
                    durum_d = BIB_BITTI;
                    if (!yazma) sonuc_d = yuk_sonuc;
                end
            end
            default: begin
                durum_d = BIB_BOSTA;
                hata_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bib_adr_o        = '0;
        bib_veri_o       = '0;
        bib_veri_maske_o = '0;
        if (durum_q == BIB_ILK) begin
            bib_adr_o = hizali_adr;
            if (yazma) begin
                bib_veri_o       = yaz_veri[VERI_GENISLIGI-1:0];
                bib_veri_maske_o = yaz_maske[NB-1:0];
            end
        end else if (durum_q == BIB_IKINCI) begin
            bib_adr_o = hizali_adr + ADRES_GENISLIGI'(NB);
            if (yazma) begin
                bib_veri_o       = yaz_veri[2*VERI_GENISLIGI-1:VERI_GENISLIGI];
                bib_veri_maske_o = yaz_maske[2*NB-1:NB];
            end
        end
    end

    assign bib_sec_o = aktif && !ddb_durdur_i;
    assign mesgul_o  = (durum_q != BIB_BOSTA);
    assign bitti_o   = (durum_q == BIB_BITTI);
    assign hata_o    = (durum_q == BIB_BITTI) && hata_q;
    assign sonuc_o   = sonuc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BIB_BOSTA;
            kontrol_q <= '0;
            adr_q     <= '0;
            deger_q   <= '0;
            hata_q    <= 1'b0;
            tampon_q  <= '0;
            sonuc_q   <= '0;
        end else begin
            durum_q  <= durum_d;
            hata_q   <= hata_d;
            tampon_q <= tampon_d;
            sonuc_q  <= sonuc_d;
            if (kabul) begin
                kontrol_q <= kontrol_i;
                adr_q     <= adr_i;
                deger_q   <= deger_i;
            end
        end
    end

endmodule

// File: tb/tb_hizasiz_bellek_islem_birimi.sv
// Directed bench: 32-bit split, 32-bit reject and 64-bit instances driven through one bus model.
module tb_hizasiz_bellek_islem_birimi;
    import hizasiz_bellek_islem_birimi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  basla_v = '0;
    logic [2:0]  kontrol = '0;
    logic [31:0] adr = '0;
    logic [31:0] deger = '0;
    logic        ddb = 1'b0;
    logic        bib_durdur = 1'b0;
    logic [63:0] rd_veri = '0;
    int          hedef = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic        mes32, bit32, hat32, sec32, mesr, bitr, hatr, secr, mes64, bit64, hat64, sec64;
    logic [31:0] son32, sonr, son64, adr32, adrr, adr64, veri32, verir;
    logic [63:0] veri64;
    logic [3:0]  mas32, masr;
    logic [7:0]  mas64;

    hizasiz_bellek_islem_birimi #(.VERI_GENISLIGI(32), .ADRES_GENISLIGI(32), .HIZASIZ_DESTEK(1)) dut32 (
        .clk_i(clk), .rst_i(rst), .basla_i(basla_v[0]), .kontrol_i(kontrol), .adr_i(adr),
        .deger_i(deger), .ddb_durdur_i(ddb), .mesgul_o(mes32), .bitti_o(bit32), .hata_o(hat32),
        .sonuc_o(son32), .bib_veri_i(rd_veri[31:0]), .bib_durdur_i(bib_durdur),
        .bib_veri_o(veri32), .bib_adr_o(adr32), .bib_veri_maske_o(mas32), .bib_sec_o(sec32));

    hizasiz_bellek_islem_birimi #(.VERI_GENISLIGI(32), .ADRES_GENISLIGI(32), .HIZASIZ_DESTEK(0)) dutr (
        .clk_i(clk), .rst_i(rst), .basla_i(basla_v[1]), .kontrol_i(kontrol), .adr_i(adr),
        .deger_i(deger), .ddb_durdur_i(ddb), .mesgul_o(mesr), .bitti_o(bitr), .hata_o(hatr),
        .sonuc_o(sonr), .bib_veri_i(rd_veri[31:0]), .bib_durdur_i(bib_durdur),
        .bib_veri_o(verir), .bib_adr_o(adrr), .bib_veri_maske_o(masr), .bib_sec_o(secr));

    hizasiz_bellek_islem_birimi #(.VERI_GENISLIGI(64), .ADRES_GENISLIGI(32), .HIZASIZ_DESTEK(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .basla_i(basla_v[2]), .kontrol_i(kontrol), .adr_i(adr),
        .deger_i(deger), .ddb_durdur_i(ddb), .mesgul_o(mes64), .bitti_o(bit64), .hata_o(hat64),
        .sonuc_o(son64), .bib_veri_i(rd_veri), .bib_durdur_i(bib_durdur),
        .bib_veri_o(veri64), .bib_adr_o(adr64), .bib_veri_maske_o(mas64), .bib_sec_o(sec64));

    logic        o_mesgul, o_bitti, o_hata, o_sec;
    logic [31:0] o_sonuc, o_adr;
    logic [63:0] o_veri;
    logic [7:0]  o_maske;

    always_comb begin
        o_mesgul = 1'b0; o_bitti = 1'b0; o_hata = 1'b0; o_sec = 1'b0;
        o_sonuc = '0; o_adr = '0; o_veri = '0; o_maske = '0;
        case (hedef)
            0: begin
                o_mesgul = mes32; o_bitti = bit32; o_hata = hat32; o_sec = sec32;
                o_sonuc = son32; o_adr = adr32; o_veri = {32'h0, veri32}; o_maske = {4'h0, mas32};
            end
            1: begin
                o_mesgul = mesr; o_bitti = bitr; o_hata = hatr; o_sec = secr;
                o_sonuc = sonr; o_adr = adrr; o_veri = {32'h0, verir}; o_maske = {4'h0, masr};
            end
            default: begin
                o_mesgul = mes64; o_bitti = bit64; o_hata = hat64; o_sec = sec64;
                o_sonuc = son64; o_adr = adr64; o_veri = veri64; o_maske = mas64;
            end
        endcase
    end

    typedef struct {
        int          n_bus;
        logic [31:0] adr0, adr1;
        logic [63:0] v0, v1;
        logic [7:0]  m0, m1;
        int          bitti_cyc;
        logic        hata;
        logic [31:0] sonuc;
        logic        kararli;
    } islem_t;

    typedef struct {
        logic [2:0]  k;
        logic [31:0] a, d;
        logic [63:0] r0, r1;
        int          n;
        logic [31:0] ea0, ea1;
        logic [63:0] ev0, ev1;
        logic [7:0]  em0, em1;
        int          ecyc;
        logic [31:0] es;
    } vek_t;

    task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    // Runs one request on instance h; the bus model stalls the first durdur_n bus cycles.
    task automatic islem(input int h, input logic [2:0] k, input logic [31:0] a,
                         input logic [31:0] d, input logic [63:0] r0, input logic [63:0] r1,
                         input int durdur_n, output islem_t s);
        int  kalan;
        bit  yeni;
        s.n_bus = 0; s.adr0 = '0; s.adr1 = '0; s.v0 = '0; s.v1 = '0; s.m0 = '0; s.m1 = '0;
        s.bitti_cyc = -1; s.hata = 1'b0; s.sonuc = '0; s.kararli = 1'b1;
        kalan = durdur_n;
        yeni = 1'b1;
        @(negedge clk);
        hedef = h; kontrol = k; adr = a; deger = d;
        basla_v = '0; basla_v[h] = 1'b1;
        @(posedge clk);
        #1 basla_v = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (o_sec) begin
                if (yeni) begin
                    if (s.n_bus == 0) begin s.adr0 = o_adr; s.v0 = o_veri; s.m0 = o_maske; end
                    else begin s.adr1 = o_adr; s.v1 = o_veri; s.m1 = o_maske; end
                    yeni = 1'b0;
                end else if ((s.n_bus == 0 && {o_adr, o_veri, o_maske} != {s.adr0, s.v0, s.m0}) ||
                             (s.n_bus == 1 && {o_adr, o_veri, o_maske} != {s.adr1, s.v1, s.m1})) begin
                    s.kararli = 1'b0;
                end
                if (kalan > 0) begin
                    bib_durdur = 1'b1;
                    kalan--;
                end else begin
                    bib_durdur = 1'b0;
                    rd_veri = (s.n_bus == 0) ? r0 : r1;
                    s.n_bus++;
                    yeni = 1'b1;
                end
            end else begin
                bib_durdur = 1'b0;
            end
            if (o_bitti) begin
                s.bitti_cyc = cyc;
                s.hata = o_hata;
                s.sonuc = o_sonuc;
                break;
            end
        end
        bib_durdur = 1'b0;
    endtask

    vek_t   tab[10];
    islem_t s;
    bit     bitti_gor;

    initial begin
        tab[0] = '{BIB_LW, 32'h100, '0, 64'hDEADBEEF, '0, 1, 32'h100, '0, '0, '0, '0, '0, 2, 32'hDEADBEEF};
        tab[1] = '{BIB_LH, 32'h103, '0, 64'h80000000, 64'hFF, 2, 32'h100, 32'h104, '0, '0, '0, '0, 3,
                   32'hFFFFFF80};
        tab[2] = '{BIB_SW, 32'h106, 32'h11223344, '0, '0, 2, 32'h104, 32'h108, 64'h33440000,
                   64'h00001122, 8'hC, 8'h3, 3, 32'hFFFFFF80};
        tab[3] = '{BIB_LBU, 32'h102, '0, 64'h12345678, '0, 1, 32'h100, '0, '0, '0, '0, '0, 2, 32'h34};
        tab[4] = '{BIB_LB, 32'h101, '0, 64'h00009A00, '0, 1, 32'h100, '0, '0, '0, '0, '0, 2, 32'hFFFFFF9A};
        tab[5] = '{BIB_LHU, 32'h102, '0, 64'hBEEF0000, '0, 1, 32'h100, '0, '0, '0, '0, '0, 2, 32'hBEEF};
        tab[6] = '{BIB_SB, 32'h103, 32'hFFFFFFAB, '0, '0, 1, 32'h100, '0, 64'hAB000000, '0, 8'h8, '0, 2,
                   32'hBEEF};
        tab[7] = '{BIB_SH, 32'h101, 32'h12345678, '0, '0, 1, 32'h100, '0, 64'h00567800, '0, 8'h6, '0, 2,
                   32'hBEEF};
        tab[8] = '{BIB_LW, 32'h102, '0, 64'hAABBCCDD, 64'h11223344, 2, 32'h100, 32'h104, '0, '0, '0, '0, 3,
                   32'h3344AABB};
        tab[9] = '{BIB_LW, 32'hFFFFFFFE, '0, 64'h55667788, 64'h00001199, 2, 32'hFFFFFFFC, 32'h0, '0, '0,
                   '0, '0, 3, 32'h11995566};

        // Reset state while reset is held.
        #12;
        chk("reset_ctrl", {o_mesgul, o_bitti, o_hata, o_sec, o_maske}, '0);
        chk("reset_adr_veri", {o_adr, o_veri}, '0);
        chk("reset_sonuc", o_sonuc, '0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            islem(0, tab[i].k, tab[i].a, tab[i].d, tab[i].r0, tab[i].r1, 0, s);
            chk($sformatf("v%0d_nbus", i), 64'(s.n_bus), 64'(tab[i].n));
            chk($sformatf("v%0d_adr0", i), s.adr0, tab[i].ea0);
            chk($sformatf("v%0d_mask0", i), s.m0, tab[i].em0);
            if (bib_yazma(tab[i].k)) chk($sformatf("v%0d_veri0", i), s.v0, tab[i].ev0);
            if (tab[i].n == 2) begin
                chk($sformatf("v%0d_adr1", i), s.adr1, tab[i].ea1);
                chk($sformatf("v%0d_mask1", i), s.m1, tab[i].em1);
                if (bib_yazma(tab[i].k)) chk($sformatf("v%0d_veri1", i), s.v1, tab[i].ev1);
            end
            chk($sformatf("v%0d_bitti_cyc", i), 64'(s.bitti_cyc), 64'(tab[i].ecyc));
            chk($sformatf("v%0d_hata", i), s.hata, 1'b0);
            chk($sformatf("v%0d_sonuc", i), s.sonuc, tab[i].es);
        end

        // Reset during the second half of a crossing load.
        @(negedge clk);
        hedef = 0; kontrol = BIB_LH; adr = 32'h103; deger = '0; basla_v = 3'b001;
        @(posedge clk);
        #1 basla_v = '0;
        @(negedge clk);
        chk("orta_ilk_sec", o_sec, 1'b1);
        rd_veri = 64'h80000000;
        @(negedge clk);
        chk("orta_ikinci_sec", o_sec, 1'b1);
        chk("orta_ikinci_adr", o_adr, 32'h104);
        rst = 1'b0;
        #1;
        chk("orta_rst_ctrl", {o_mesgul, o_bitti, o_hata, o_sec, o_maske}, '0);
        chk("orta_rst_adr_veri", {o_adr, o_veri}, '0);
        chk("orta_rst_sonuc", o_sonuc, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bitti_gor = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_bitti || o_mesgul) bitti_gor = 1'b1;
        end
        chk("orta_rst_sessiz", bitti_gor, 1'b0);
        islem(0, BIB_LW, 32'h100, '0, 64'hDEADBEEF, '0, 0, s);
        chk("rst_sonra_cyc", 64'(s.bitti_cyc), 64'd2);
        chk("rst_sonra_sonuc", s.sonuc, 32'hDEADBEEF);

        // Rejecting instance: crossing access errors out without a bus cycle.
        islem(1, BIB_LW, 32'h101, '0, 64'h12345678, '0, 0, s);
        chk("red_nbus", 64'(s.n_bus), 64'd0);
        chk("red_cyc", 64'(s.bitti_cyc), 64'd1);
        chk("red_hata", s.hata, 1'b1);
        chk("red_sonuc", s.sonuc, '0);
        islem(1, BIB_LW, 32'h104, '0, 64'hCAFEF00D, '0, 0, s);
        chk("red_hizali_hata", s.hata, 1'b0);
        chk("red_hizali_sonuc", s.sonuc, 32'hCAFEF00D);
        islem(1, BIB_LH, 32'h103, '0, 64'h5555, '0, 0, s);
        chk("red2_hata", s.hata, 1'b1);
        chk("red2_sonuc", s.sonuc, 32'hCAFEF00D);

        // 64-bit bus: stalled byte store, then crossing word load.
        islem(2, BIB_SB, 32'h10D, 32'h000000AB, '0, '0, 3, s);
        chk("w64_sb_adr", s.adr0, 32'h108);
        chk("w64_sb_mask", s.m0, 8'h20);
        chk("w64_sb_veri", s.v0, 64'h0000AB00_00000000);
        chk("w64_sb_kararli", s.kararli, 1'b1);
        chk("w64_sb_cyc", 64'(s.bitti_cyc), 64'd5);
        chk("w64_sb_sonuc", s.sonuc, '0);
        islem(2, BIB_LW, 32'h10E, '0, 64'hBBAA0000_00000000, 64'h00000000_0000DDCC, 0, s);
        chk("w64_lw_nbus", 64'(s.n_bus), 64'd2);
        chk("w64_lw_adr0", s.adr0, 32'h108);
        chk("w64_lw_adr1", s.adr1, 32'h110);
        chk("w64_lw_mask", {s.m0, s.m1}, '0);
        chk("w64_lw_cyc", 64'(s.bitti_cyc), 64'd3);
        chk("w64_lw_sonuc", s.sonuc, 32'hDDCCBBAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
